// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker, favours the side that did not win last
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[GNT_I] = req[GNT_I] & (!req[GNT_D] | (last == GNT_D));
        gnt[GNT_D] = req[GNT_D] & (!req[GNT_I] | (last == GNT_I));
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-MM master port between fetch and memory stages
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_waitrequest,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_waitrequest,
    output logic                m_read,
    output logic                m_write,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest
);
    state_t state, state_nxt;
    logic last_grant;
    logic [1:0] gnt;
    logic cmd_we;
    logic done_i, done_d;

    rr_arb2 u_pick (
        .req ({d_req, if_req}),
        .last(last_grant),
        .gnt (gnt)
    );

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = gnt[GNT_D] ? GRANT_D : gnt[GNT_I] ? GRANT_I : IDLE;
        else if (!m_waitrequest)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Command registers: bus outputs never see requester inputs directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant   <= GNT_D;
            cmd_we       <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_byteenable <= '0;
        end else if (state == IDLE && gnt[GNT_D]) begin
            last_grant   <= GNT_D;
            cmd_we       <= d_we;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
            m_byteenable <= d_we ? d_be : '1;
        end else if (state == IDLE && gnt[GNT_I]) begin
            last_grant   <= GNT_I;
            cmd_we       <= 1'b0;
            m_addr       <= if_addr;
            m_wdata      <= '0;
            m_byteenable <= '1;
        end
    end

    always_comb begin
        done_i         = (state == GRANT_I) && !m_waitrequest;
        done_d         = (state == GRANT_D) && !m_waitrequest;
        m_read         = (state == GRANT_I) || (state == GRANT_D && !cmd_we);
        m_write        = (state == GRANT_D) && cmd_we;
        if_waitrequest = !done_i;
        d_waitrequest  = !done_d;
        if_rdata       = done_i ? m_readdata : '0;
        d_rdata        = (done_d && !cmd_we) ? m_readdata : '0;
    end
endmodule
